// File: rtl/sr_cfg_seq.sv
// Host-side sequencer for Top_SR: assembles the configuration word from 32-bit
// writes, runs one write/readback cycle, and exposes the readback for the host.
module sr_cfg_seq #(
  parameter int WIDTH     = 170,
  parameter int DIV_WIDTH = 6,
  parameter int START_LEN = 2,
  parameter int TO_WIDTH  = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [31:0]          cfg_data,
  input  logic                 cfg_wr,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 go,
  output logic [WIDTH-1:0]     sr_din,
  output logic [DIV_WIDTH-1:0] sr_div,
  output logic                 sr_start,
  input  logic [WIDTH-1:0]     sr_dout,
  input  logic                 sr_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic                 timeout,
  output logic                 err,
  output logic [31:0]          rb_data,
  input  logic                 rb_rd,
  output logic                 rb_empty
);

  localparam int NWORDS = (WIDTH + 31) / 32;
  localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int SC_W   = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, CHECK} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     shadow, shadow_wr, rb_img;
  logic [PTR_W-1:0]     wr_ptr, rb_ptr;
  logic [SC_W-1:0]      start_cnt;
  logic [TO_WIDTH-1:0]  timer, timer_inc;
  logic                 go_ok, go_bad, wr_ok, wr_bad;
  logic                 start_end, wait_expire;

  // Word-sliced view of the shadow with the current write applied; bits at or
  // above WIDTH in the last word simply have no destination.
  always_comb begin
    shadow_wr = shadow;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i / 32) == int'(wr_ptr)) shadow_wr[i] = cfg_data[i % 32];
    end
  end

  always_comb begin
    rb_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i / 32) == int'(rb_ptr)) rb_data[i % 32] = rb_img[i];
    end
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    go_ok       = (state == IDLE) && go && !cfg_wr && (div_in != '0);
    go_bad      = (state == IDLE) && go && !go_ok;
    wr_ok       = (state == IDLE) && cfg_wr;
    wr_bad      = (state != IDLE) && cfg_wr;
    start_end   = (state == START) && (start_cnt == SC_W'(START_LEN - 1));
    timer_inc   = timer + TO_WIDTH'(1);
    wait_expire = (state == WAIT) && !sr_valid && (&timer_inc);
    state_nxt   = state;
    case (state)
      IDLE:    if (go_ok) state_nxt = START;
      START:   if (start_end) state_nxt = WAIT;
      WAIT:    if (sr_valid) state_nxt = CHECK;
               else if (wait_expire) state_nxt = IDLE;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: synchronous reset inside the clocked block, and <= for all state so
  // every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      // NOTE: the shadow and readback image are plain flops and are cleared on reset.
      shadow    <= '0;
      rb_img    <= '0;
      wr_ptr    <= '0;
      rb_ptr    <= '0;
      start_cnt <= '0;
      timer     <= '0;
      sr_din    <= '0;
      sr_div    <= '0;
      sr_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      timeout   <= 1'b0;
      err       <= 1'b0;
      rb_empty  <= 1'b1;
    end else begin
      done <= 1'b0;

      if (wr_ok) begin
        shadow <= shadow_wr;
        wr_ptr <= (wr_ptr == PTR_W'(NWORDS - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end

      if (go_ok)                err <= 1'b0;
      else if (go_bad || wr_bad) err <= 1'b1;

      if (rb_rd && !rb_empty) begin
        if (rb_ptr == PTR_W'(NWORDS - 1)) begin
          rb_ptr   <= '0;
          rb_empty <= 1'b1;
        end else begin
          rb_ptr <= rb_ptr + PTR_W'(1);
        end
      end

      // An accepted launch discards any unread readback words.
      if (go_ok) begin
        sr_din    <= shadow;
        sr_div    <= div_in;
        sr_start  <= 1'b1;
        start_cnt <= '0;
        busy      <= 1'b1;
        match     <= 1'b0;
        timeout   <= 1'b0;
        rb_empty  <= 1'b1;
        rb_ptr    <= '0;
      end

      if (state == START) begin
        if (start_end) begin
          sr_start <= 1'b0;
          timer    <= '0;
        end else begin
          start_cnt <= start_cnt + SC_W'(1);
        end
      end

      // Valid takes priority over an expiry landing in the same cycle.
      if (state == WAIT) begin
        timer <= timer_inc;
        if (sr_valid) begin
          rb_img <= sr_dout;
        end else if (wait_expire) begin
          timeout <= 1'b1;
          match   <= 1'b0;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      end

      if (state == CHECK) begin
        match    <= (rb_img == sr_din);
        done     <= 1'b1;
        busy     <= 1'b0;
        rb_ptr   <= '0;
        rb_empty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sr_cfg_seq.sv
// Randomized scoreboard bench for sr_cfg_seq with a loopback Top_SR responder and
// a word-array model of the configuration shadow.
module tb_sr_cfg_seq;

  localparam int WIDTH     = 170;
  localparam int DIV_WIDTH = 6;
  localparam int START_LEN = 2;
  localparam int TO_WIDTH  = 4;
  localparam int NWORDS    = (WIDTH + 31) / 32;
  localparam int TO_CYC    = (1 << TO_WIDTH) - 1;

  logic                 clk_in, rst_n;
  logic [31:0]          cfg_data;
  logic                 cfg_wr, go, sr_start, sr_valid;
  logic [DIV_WIDTH-1:0] div_in, sr_div;
  logic [WIDTH-1:0]     sr_din, sr_dout;
  logic                 busy, done, match, timeout, err, rb_rd, rb_empty;
  logic [31:0]          rb_data;

  sr_cfg_seq #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .START_LEN(START_LEN),
               .TO_WIDTH(TO_WIDTH)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_wr(cfg_wr),
    .div_in(div_in), .go(go), .sr_din(sr_din), .sr_div(sr_div),
    .sr_start(sr_start), .sr_dout(sr_dout), .sr_valid(sr_valid), .busy(busy),
    .done(done), .match(match), .timeout(timeout), .err(err),
    .rb_data(rb_data), .rb_rd(rb_rd), .rb_empty(rb_empty)
  );

  typedef struct {
    logic [WIDTH-1:0]     din;
    logic [DIV_WIDTH-1:0] div;
    bit                   match;
    bit                   tout;
    bit                   err;
    int                   go_cyc;
    logic [WIDTH-1:0]     img;
  } exp_t;

  exp_t                 sb_q[$];
  logic [31:0]          rb_q[$];
  exp_t                 mon_e;

  int                   n_checks = 0;
  int                   n_fail   = 0;
  int                   cyc      = 0;

  logic [31:0]          sh [NWORDS];
  int                   wptr;
  logic [WIDTH-1:0]     last_din;
  logic [DIV_WIDTH-1:0] last_div;

  bit                   resp_never;
  logic [WIDTH-1:0]     resp_flip;
  int                   resp_delay;
  int                   valid_cyc, rise_cyc, fall_cyc;
  bit                   prev_start;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] shadow_vec();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = sh[i / 32][i % 32];
    return v;
  endfunction

  function automatic logic [31:0] word_of(input logic [WIDTH-1:0] img, input int w);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) if (w * 32 + j < WIDTH) r[j] = img[w * 32 + j];
    return r;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NWORDS; w++) sh[w] = '0;
    wptr     = 0;
    last_din = '0;
    last_div = '0;
    rb_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     WIDTH'(busy),     '0);
    check({tag, "_done"},     WIDTH'(done),     '0);
    check({tag, "_match"},    WIDTH'(match),    '0);
    check({tag, "_timeout"},  WIDTH'(timeout),  '0);
    check({tag, "_err"},      WIDTH'(err),      '0);
    check({tag, "_sr_start"}, WIDTH'(sr_start), '0);
    check({tag, "_rb_empty"}, WIDTH'(rb_empty), WIDTH'(1'b1));
    check({tag, "_sr_din"},   sr_din,           '0);
    check({tag, "_sr_div"},   WIDTH'(sr_div),   '0);
    check({tag, "_rb_data"},  WIDTH'(rb_data),  '0);
  endtask

  // Driver tasks start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    cfg_data = d;
    cfg_wr   = 1'b1;
    @(posedge clk_in); #1;
    cfg_wr   = 1'b0;
    sh[wptr] = d;
    wptr     = (wptr + 1) % NWORDS;
  endtask

  task automatic wait_done();
    bit seen = 0;
    int n    = 0;
    while (!seen && n < 200) begin
      @(negedge clk_in);
      if (done === 1'b1) seen = 1;
      n++;
    end
    check("done_seen", WIDTH'(seen), WIDTH'(1'b1));
    if (!seen) sb_q.delete();
    @(posedge clk_in); #1;
  endtask

  task automatic launch(input logic [DIV_WIDTH-1:0] div, input bit never,
                        input logic [WIDTH-1:0] flip, input int delay,
                        input bit bad_wr, input bit busy_go);
    exp_t e;
    resp_never = never;
    resp_flip  = flip;
    resp_delay = delay;
    e.din      = shadow_vec();
    e.div      = div;
    e.tout     = never;
    e.match    = !never && (flip == '0);
    e.err      = bad_wr;
    e.go_cyc   = cyc;
    e.img      = e.din ^ flip;
    rb_q.delete();
    sb_q.push_back(e);
    go     = 1'b1;
    div_in = div;
    @(posedge clk_in); #1;
    go       = 1'b0;
    last_din = e.din;
    last_div = div;
    repeat (START_LEN) @(posedge clk_in);
    #1;
    if (bad_wr || busy_go) begin
      cfg_wr   = bad_wr;
      cfg_data = $urandom;
      go       = busy_go;
      div_in   = DIV_WIDTH'($urandom);
      @(posedge clk_in); #1;
      cfg_wr = 1'b0;
      go     = 1'b0;
    end
    wait_done();
  endtask

  task automatic pop(input int n);
    if (n > 0) begin
      rb_rd = 1'b1;
      repeat (n) @(posedge clk_in);
      #1;
      rb_rd = 1'b0;
    end
  endtask

  task automatic reject();
    go     = 1'b1;
    div_in = '0;
    @(posedge clk_in); #1;
    go = 1'b0;
    @(negedge clk_in);
    check("reject_err",      WIDTH'(err),      WIDTH'(1'b1));
    check("reject_sr_start", WIDTH'(sr_start), '0);
    check("reject_busy",     WIDTH'(busy),     '0);
    check("reject_sr_din",   sr_din,           last_din);
    check("reject_sr_div",   WIDTH'(sr_div),   WIDTH'(last_div));
    @(posedge clk_in); #1;
  endtask

  task automatic reset_mid(input bit in_wait);
    resp_never = 1'b1;
    go         = 1'b1;
    div_in     = DIV_WIDTH'($urandom_range(1, (1 << DIV_WIDTH) - 1));
    @(posedge clk_in); #1;
    go = 1'b0;
    if (in_wait) idle(START_LEN + 2);
    rst_n = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs(in_wait ? "rst_wait" : "rst_start");
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    model_reset();
    idle(20);
  endtask

  // Top_SR stand-in: loops sr_din back (optionally corrupted) some cycles after start falls.
  initial begin
    sr_valid = 1'b0;
    sr_dout  = '0;
    forever begin
      wait (sr_start === 1'b1);
      wait (sr_start === 1'b0);
      if (!resp_never) begin
        repeat (resp_delay) @(posedge clk_in);
        #1;
        sr_dout   = sr_din ^ resp_flip;
        sr_valid  = 1'b1;
        valid_cyc = cyc;
        @(posedge clk_in); #1;
        sr_valid = 1'b0;
      end
    end
  end

  // Monitor: pairs each done pulse and readback pop with the scoreboard.
  always @(negedge clk_in) begin
    if (sr_start === 1'b1 && !prev_start) rise_cyc = cyc;
    if (sr_start === 1'b0 && prev_start)  fall_cyc = cyc;
    prev_start = (sr_start === 1'b1);
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending launch");
      end else begin
        mon_e = sb_q.pop_front();
        check("done_match",    WIDTH'(match),    WIDTH'(mon_e.match));
        check("done_timeout",  WIDTH'(timeout),  WIDTH'(mon_e.tout));
        check("done_err",      WIDTH'(err),      WIDTH'(mon_e.err));
        check("done_busy",     WIDTH'(busy),     '0);
        check("done_sr_start", WIDTH'(sr_start), '0);
        check("done_rb_empty", WIDTH'(rb_empty), WIDTH'(mon_e.tout));
        check("done_sr_din",   sr_din,           mon_e.din);
        check("done_sr_div",   WIDTH'(sr_div),   WIDTH'(mon_e.div));
        check("start_rise_lat", WIDTH'(rise_cyc - mon_e.go_cyc), WIDTH'(1));
        check("start_len",      WIDTH'(fall_cyc - rise_cyc),     WIDTH'(START_LEN));
        if (mon_e.tout)
          check("timeout_lat", WIDTH'(cyc - fall_cyc), WIDTH'(TO_CYC));
        else
          check("valid_done_lat", WIDTH'(cyc - valid_cyc), WIDTH'(2));
        if (!mon_e.tout)
          for (int w = 0; w < NWORDS; w++) rb_q.push_back(word_of(mon_e.img, w));
      end
    end
    if (rb_rd === 1'b1) begin
      if (rb_q.size() > 0) begin
        check("rb_not_empty", WIDTH'(rb_empty), '0);
        check("rb_word",      WIDTH'(rb_data),  WIDTH'(rb_q.pop_front()));
      end else begin
        check("rb_empty_set", WIDTH'(rb_empty), WIDTH'(1'b1));
      end
    end
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got no finish expected finish within cycle budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [WIDTH-1:0] f;
    int               r;
    rst_n      = 1'b0;
    cfg_data   = '0;
    cfg_wr     = 1'b0;
    div_in     = '0;
    go         = 1'b0;
    rb_rd      = 1'b0;
    resp_never = 1'b1;
    resp_flip  = '0;
    resp_delay = 0;
    model_reset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("por");
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    idle(2);

    // Known word pattern, clean loopback.
    wr(32'hB);
    for (int i = 0; i < 4; i++) wr(32'h0);
    wr(32'h200);
    check("hold_din_after_wr", sr_din, last_din);
    launch(6'd1, 1'b0, '0, 3, 1'b0, 1'b0);

    // Bit 0 corrupted: mismatch, full drain plus one pop while empty.
    f = '0; f[0] = 1'b1;
    launch(6'd1, 1'b0, f, 5, 1'b0, 1'b0);
    pop(NWORDS + 1);

    // No valid at all.
    launch(6'd3, 1'b1, '0, 0, 1'b0, 1'b0);
    pop(2);

    // Rejected launch, then a write and a go while busy, then shadow unchanged.
    reject();
    launch(6'd2, 1'b0, '0, 4, 1'b1, 1'b1);
    launch(6'd5, 1'b0, '0, 2, 1'b0, 1'b0);
    pop(3);

    reset_mid(1'b0);
    reset_mid(1'b1);

    // Pointer wrap: seventh write lands in word 0.
    for (int i = 0; i < NWORDS + 1; i++) wr($urandom);
    launch(6'd7, 1'b0, '0, 14, 1'b0, 1'b0);
    pop(NWORDS);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 3);
      for (int i = 0; i < r * 2; i++) wr($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        reject();
      end else if (r == 1) begin
        reset_mid(1'($urandom_range(0, 1)));
      end else begin
        f = '0;
        if ($urandom_range(0, 2) == 0) f[$urandom_range(0, WIDTH - 1)] = 1'b1;
        launch(DIV_WIDTH'($urandom_range(1, (1 << DIV_WIDTH) - 1)), r == 2, f,
               ($urandom_range(0, 3) == 0) ? 14 : $urandom_range(0, 13),
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        pop($urandom_range(0, 8));
      end
    end

    idle(10);
    check("sb_drained", WIDTH'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
